io_bus_master: RTL

IO_BUS_MASTER -- requirements
Module: io_bus_master

---
 rtl/io_bus_master.sv | 135 +++++++++++++
 1 files changed

// File: rtl/io_bus_master.sv
// io_bus_master: CPU-side request to a shared tri-state peripheral bus.
// Four-phase transfer IDLE -> SETUP -> ACCESS(xN) -> HOLD with one-hot chip selects.
module io_bus_master #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    inout  wire  [31:0] data_io,
    output logic [15:0] cs_en,
    output logic        wt_en,
    output logic        rd_en,
    output logic [3:0]  addr_out
);

    // A zero wait count still needs one ACCESS cycle to strobe the device
    localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CW = (WC > 1) ? $clog2(WC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [7:0]    addr_q;
    logic [31:0]   wdata_q;
    logic          drive;
    logic          start;
    logic          last_acc;

    assign start    = (state == IDLE) && req;
    assign last_acc = (state == ACCESS) && (cnt == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (cnt == '0) state_nx = HOLD;
            HOLD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Wait counter: reloaded on SETUP entry, counts ACCESS cycles down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_LOAD;
        end else if ((state == ACCESS) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Request latch: the bus only ever sees the values captured at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Read capture on the edge closing the final ACCESS cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (last_acc && !we_q) begin
            rdata <= data_io;
        end
    end

    // Bus strobes, decoded purely from state so reset drops them at once
    always_comb begin
        cs_en    = '0;
        addr_out = 4'hF;
        wt_en    = 1'b0;
        rd_en    = 1'b0;
        ack      = 1'b0;
        drive    = 1'b0;
        busy     = (state != IDLE);
        unique case (state)
            SETUP: begin
                cs_en    = 16'(1) << addr_q[7:4];
                addr_out = addr_q[3:0];
                wt_en    = we_q;
                drive    = we_q;
            end
            ACCESS: begin
                cs_en    = 16'(1) << addr_q[7:4];
                addr_out = addr_q[3:0];
                wt_en    = we_q;
                rd_en    = !we_q;
                drive    = we_q;
            end
            HOLD: begin
                ack = 1'b1;
            end
            default: begin
                ack = 1'b0;
            end
        endcase
    end

    assign data_io = drive ? wdata_q : 32'hz;

endmodule
